// File: rtl/fuzzy_1_pkg.sv
// Shared constants and helpers for the two-input interval type-2 fuzzy controller.
// Membership breakpoints, centroid table, frame step codes and datapath widths.
package fuzzy_1_pkg;

    localparam int W_W   = 9;
    localparam int W_SUM = 13;
    localparam int W_NUM = 21;

    typedef logic [3:0] step_t;

    localparam step_t ST_CLR        = 4'd0;
    localparam step_t ST_RULE_FIRST = 4'd1;
    localparam step_t ST_RULE_LAST  = 4'd9;
    localparam step_t ST_DIV        = 4'd10;
    localparam step_t ST_LAST       = 4'd11;

    localparam logic [7:0] U_LO_B  = 8'd128;
    localparam logic [7:0] U_MID_A = 8'd64;
    localparam logic [7:0] U_MID_B = 8'd192;
    localparam logic [7:0] U_HI_A  = 8'd128;

    localparam logic [7:0] L_LO_B  = 8'd112;
    localparam logic [7:0] L_MID_A = 8'd80;
    localparam logic [7:0] L_MID_B = 8'd176;
    localparam logic [7:0] L_HI_A  = 8'd144;

    // index 0 = Low, 1 = Mid, 2 = High
    typedef logic [2:0][7:0] grade3_t;

    function automatic logic [7:0] sat4(input logic [7:0] d);
        logic [9:0] m;
        m = {d, 2'b00};
        sat4 = (m > 10'd255) ? 8'd255 : m[7:0];
    endfunction

    function automatic logic [7:0] ramp_up(input logic [7:0] x,
                                           input logic [7:0] a);
        ramp_up = (x <= a) ? 8'd0 : sat4(x - a);
    endfunction

    function automatic logic [7:0] ramp_dn(input logic [7:0] x,
                                           input logic [7:0] b);
        ramp_dn = (x >= b) ? 8'd0 : sat4(b - x);
    endfunction

    function automatic logic [7:0] min8(input logic [7:0] a,
                                        input logic [7:0] b);
        min8 = (a < b) ? a : b;
    endfunction

    function automatic logic [7:0] centroid(input logic [2:0] idx);
        logic [7:0] c;
        c = 8'd0;
        case (idx)
            3'd1:    c = 8'd64;
            3'd2:    c = 8'd128;
            3'd3:    c = 8'd192;
            3'd4:    c = 8'd255;
            default: c = 8'd0;
        endcase
        centroid = c;
    endfunction

endpackage

// File: rtl/fuzzy_1_mf.sv
// Trapezoidal upper and lower membership grades for one 8-bit input.
// Mid sets are the min of a rising and a falling saturated ramp.
module fuzzy_1_mf
    import fuzzy_1_pkg::*;
(
    input  logic [7:0] x,
    output grade3_t    umf,
    output grade3_t    lmf
);

    always_comb begin
        umf[0] = ramp_dn(x, U_LO_B);
        umf[1] = min8(ramp_up(x, U_MID_A), ramp_dn(x, U_MID_B));
        umf[2] = ramp_up(x, U_HI_A);
        lmf[0] = ramp_dn(x, L_LO_B);
        lmf[1] = min8(ramp_up(x, L_MID_A), ramp_dn(x, L_MID_B));
        lmf[2] = ramp_up(x, L_HI_A);
    end

endmodule

// File: rtl/fuzzy_1_ctrl.sv
// Fuzzy controller top: 12-step frame sequencer, sequential rule
// evaluation, weight accumulators and weighted-average defuzzifier.
module fuzzy_1_ctrl
    import fuzzy_1_pkg::*;
(
    input  logic       Srst,
    input  logic [7:0] Entrada_01,
    input  logic [7:0] Entrada_02,
    input  logic       EN_REGRAS,
    output logic [7:0] saida_defuzzy,
    input  logic       clk_0,
    output logic       Sclk_int,
    output logic [3:0] SSequencia_regras,
    output logic       SReset_Memoria,
    output logic [5:0] FOU_ATIVO
);

    step_t            step_q;
    step_t            step_d;
    logic             sclk_q;
    logic [7:0]       x1_q;
    logic [7:0]       x2_q;
    logic [W_SUM-1:0] w_acc;
    logic [W_NUM-1:0] n_acc;
    logic [7:0]       out_q;

    grade3_t u1, l1, u2, l2;

    logic [1:0]       sel_i;
    logic [1:0]       sel_j;
    logic [7:0]       fu;
    logic [7:0]       fl;
    logic [W_W-1:0]   w;
    logic [7:0]       c;
    logic [16:0]      wc;
    logic             acc_en;
    logic [W_NUM-1:0] quo;
    logic [7:0]       div_out;

    fuzzy_1_mf u_mf1 (.x(x1_q), .umf(u1), .lmf(l1));
    fuzzy_1_mf u_mf2 (.x(x2_q), .umf(u2), .lmf(l2));

    always_comb begin
        step_d = (step_q == ST_LAST) ? ST_CLR : step_q + 4'd1;
    end

    // rule k = step-1 selects input-1 set i = k/3, input-2 set j = k%3
    always_comb begin
        sel_i = 2'd0;
        sel_j = 2'd0;
        case (step_q)
            4'd2:    begin sel_i = 2'd0; sel_j = 2'd1; end
            4'd3:    begin sel_i = 2'd0; sel_j = 2'd2; end
            4'd4:    begin sel_i = 2'd1; sel_j = 2'd0; end
            4'd5:    begin sel_i = 2'd1; sel_j = 2'd1; end
            4'd6:    begin sel_i = 2'd1; sel_j = 2'd2; end
            4'd7:    begin sel_i = 2'd2; sel_j = 2'd0; end
            4'd8:    begin sel_i = 2'd2; sel_j = 2'd1; end
            4'd9:    begin sel_i = 2'd2; sel_j = 2'd2; end
            default: begin sel_i = 2'd0; sel_j = 2'd0; end
        endcase
    end

    always_comb begin
        fu     = min8(u1[sel_i], u2[sel_j]);
        fl     = min8(l1[sel_i], l2[sel_j]);
        w      = EN_REGRAS ? ({1'b0, fu} + {1'b0, fl}) : '0;
        c      = centroid({1'b0, sel_i} + {1'b0, sel_j});
        wc     = w * c;
        acc_en = (step_q >= ST_RULE_FIRST) && (step_q <= ST_RULE_LAST);
    end

    always_comb begin
        quo     = n_acc / {{(W_NUM-W_SUM){1'b0}}, w_acc};
        div_out = 8'd0;
        if (w_acc != '0) begin
            div_out = (quo > 21'd255) ? 8'd255 : quo[7:0];
        end
    end

    always_ff @(posedge clk_0 or negedge Srst) begin
        if (!Srst) begin
            step_q <= ST_CLR;
            sclk_q <= 1'b0;
            x1_q   <= 8'd0;
            x2_q   <= 8'd0;
            w_acc  <= '0;
            n_acc  <= '0;
            out_q  <= 8'd0;
        end else begin
            step_q <= step_d;
            sclk_q <= ~sclk_q;
            if (step_q == ST_CLR) begin
                x1_q  <= Entrada_01;
                x2_q  <= Entrada_02;
                w_acc <= '0;
                n_acc <= '0;
            end else if (acc_en) begin
                w_acc <= w_acc + {{(W_SUM-W_W){1'b0}}, w};
                n_acc <= n_acc + {{(W_NUM-17){1'b0}}, wc};
            end
            if (step_q == ST_DIV) begin
                out_q <= div_out;
            end
        end
    end

    always_comb begin
        saida_defuzzy     = out_q;
        Sclk_int          = sclk_q;
        SSequencia_regras = step_q;
        SReset_Memoria    = (step_q == ST_CLR);
        FOU_ATIVO = {u2[2] != 8'd0, u2[1] != 8'd0, u2[0] != 8'd0,
                     u1[2] != 8'd0, u1[1] != 8'd0, u1[0] != 8'd0};
    end

endmodule

// File: tb/tb_fuzzy_1_ctrl.sv
// Directed bench for fuzzy_1_ctrl: reset, sequencing, hand-computed
// vectors, boundary sweep against a piecewise model, mid-frame reset.
module tb_fuzzy_1_ctrl;

    logic       clk_0 = 1'b0;
    logic       Srst;
    logic [7:0] Entrada_01;
    logic [7:0] Entrada_02;
    logic       EN_REGRAS;
    logic [7:0] saida_defuzzy;
    logic       Sclk_int;
    logic [3:0] SSequencia_regras;
    logic       SReset_Memoria;
    logic [5:0] FOU_ATIVO;

    int n_chk  = 0;
    int n_fail = 0;

    fuzzy_1_ctrl dut (
        .Srst              (Srst),
        .Entrada_01        (Entrada_01),
        .Entrada_02        (Entrada_02),
        .EN_REGRAS         (EN_REGRAS),
        .saida_defuzzy     (saida_defuzzy),
        .clk_0             (clk_0),
        .Sclk_int          (Sclk_int),
        .SSequencia_regras (SSequencia_regras),
        .SReset_Memoria    (SReset_Memoria),
        .FOU_ATIVO         (FOU_ATIVO)
    );

    always #5 clk_0 = ~clk_0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int umf(input int s, input int x);
        case (s)
            0: return (x <= 64) ? 255 : (x < 128) ? (128 - x) * 4 : 0;
            1: return (x < 64) ? 0 : (x <= 128) ? sat((x - 64) * 4) :
                      (x < 192) ? (192 - x) * 4 : 0;
            default: return (x <= 128) ? 0 : (x < 192) ? (x - 128) * 4 : 255;
        endcase
    endfunction

    function automatic int lmf(input int s, input int x);
        case (s)
            0: return (x <= 48) ? 255 : (x < 112) ? (112 - x) * 4 : 0;
            1: return (x < 80) ? 0 : (x <= 128) ? sat((x - 80) * 4) :
                      (x < 176) ? sat((176 - x) * 4) : 0;
            default: return (x <= 144) ? 0 : sat((x - 144) * 4);
        endcase
    endfunction

    function automatic int model_out(input int x1, input int x2);
        int cent[5] = '{0, 64, 128, 192, 255};
        int ws = 0;
        int ns = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                int fu, fl, wt;
                fu = (umf(i, x1) < umf(j, x2)) ? umf(i, x1) : umf(j, x2);
                fl = (lmf(i, x1) < lmf(j, x2)) ? lmf(i, x1) : lmf(j, x2);
                wt = fu + fl;
                ws += wt;
                ns += wt * cent[i + j];
            end
        end
        if (ws == 0) return 0;
        return sat(ns / ws);
    endfunction

    function automatic int model_fou(input int x1, input int x2);
        int f = 0;
        for (int s = 0; s < 3; s++) begin
            if (umf(s, x1) != 0) f |= 1 << s;
            if (umf(s, x2) != 0) f |= 1 << (s + 3);
        end
        return f;
    endfunction

    task automatic apply(input int x1, input int x2, input logic en);
        @(negedge clk_0);
        Entrada_01 = x1[7:0];
        Entrada_02 = x2[7:0];
        EN_REGRAS  = en;
        repeat (24) @(negedge clk_0);
    endtask

    initial begin
        int vals[7] = '{0, 48, 64, 100, 128, 176, 255};
        int a, b, k;

        Srst       = 1'b0;
        Entrada_01 = 8'd0;
        Entrada_02 = 8'd0;
        EN_REGRAS  = 1'b1;
        repeat (3) @(negedge clk_0);
        check("rst_out",  saida_defuzzy, 0);
        check("rst_step", SSequencia_regras, 0);
        check("rst_clr",  SReset_Memoria, 1);
        check("rst_fou",  FOU_ATIVO, 6'b001001);
        check("rst_sclk", Sclk_int, 0);

        Srst = 1'b1;
        for (int n = 0; n < 26; n++) begin
            check("seq_step", SSequencia_regras, n % 12);
            check("seq_clr",  SReset_Memoria, (n % 12) == 0);
            check("seq_sclk", Sclk_int, n % 2);
            @(negedge clk_0);
        end

        apply(112, 160, 1'b1);
        check("v112_160_out", saida_defuzzy, 144);
        check("v112_160_fou", FOU_ATIVO, 6'b110011);

        apply(128, 128, 1'b1);
        check("v128_out", saida_defuzzy, 128);
        check("v128_fou", FOU_ATIVO, 6'b010010);

        apply(254, 254, 1'b1);
        check("v254_out", saida_defuzzy, 255);
        check("v254_fou", FOU_ATIVO, 6'b100100);

        apply(1, 1, 1'b1);
        check("v1_out", saida_defuzzy, 0);
        check("v1_fou", FOU_ATIVO, 6'b001001);

        apply(112, 160, 1'b0);
        check("en0_out", saida_defuzzy, 0);
        check("en0_fou", FOU_ATIVO, 6'b110011);

        for (int p = 0; p < 7; p++) begin
            for (int q = 0; q < 7; q++) begin
                apply(vals[p], vals[q], 1'b1);
                check("sweep_out", saida_defuzzy, model_out(vals[p], vals[q]));
                check("sweep_fou", FOU_ATIVO, model_fou(vals[p], vals[q]));
            end
        end

        for (int r = 0; r < 16; r++) begin
            a = $urandom_range(0, 254);
            b = $urandom_range(0, 254);
            apply(a, b, 1'b1);
            check("rand_out", saida_defuzzy, model_out(a, b));
        end

        apply(112, 160, 1'b1);
        check("pre_rst_out", saida_defuzzy, 144);
        k = 0;
        while (SSequencia_regras != 4'd5 && k < 30) begin
            @(negedge clk_0);
            k++;
        end
        check("reach_step5", SSequencia_regras, 5);
        Srst = 1'b0;
        #1;
        check("mid_rst_out",  saida_defuzzy, 0);
        check("mid_rst_step", SSequencia_regras, 0);
        check("mid_rst_clr",  SReset_Memoria, 1);
        @(negedge clk_0);
        Srst = 1'b1;
        repeat (24) @(negedge clk_0);
        check("post_rst_out", saida_defuzzy, 144);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
